// File: rtl/oled_interval_timer_if.sv
// Control/status bundle for oled_interval_timer: start/abort/mode/length in,
// busy/done/count out.
interface oled_interval_timer_if #(
    parameter int unsigned W = 4
) ();
    logic         start;
    logic         abort;
    logic         periodic;
    logic [W-1:0] ceil;
    logic         busy;
    logic         done;
    logic [W-1:0] count;

    modport master (
        output start,
        output abort,
        output periodic,
        output ceil,
        input  busy,
        input  done,
        input  count
    );

    modport slave (
        input  start,
        input  abort,
        input  periodic,
        input  ceil,
        output busy,
        output done,
        output count
    );
endinterface

// File: rtl/oled_interval_timer.sv
// Interval timer for OLED sequencing: L ticks of DIV clocks each, one-shot or
// auto-reload, with abort and optional retrigger. All outputs are registered.
module oled_interval_timer #(
    parameter int unsigned W      = 4,
    parameter int unsigned DIV    = 1,
    parameter bit          RETRIG = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    oled_interval_timer_if.slave tmr
);
    localparam int unsigned   PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PreLast = PW'(DIV - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  ceil_q, ceil_d;
    logic          periodic_q, periodic_d;

    logic          pstart;
    logic          tick;
    logic [W-1:0]  last_count;
    logic          expire;

    assign pstart     = tmr.start & ~start_q;
    assign tick       = (pre_q == PreLast);
    // W-bit wrap: ceil 0 gives last_count = 2^W-1, i.e. 2^W ticks
    assign last_count = ceil_q - W'(1);
    assign expire     = tick && (count_q == last_count);

    always_comb begin
        state_d    = state_q;
        start_d    = tmr.start;
        busy_d     = busy_q;
        done_d     = 1'b0;
        count_d    = count_q;
        pre_d      = pre_q;
        ceil_d     = ceil_q;
        periodic_d = periodic_q;

        unique case (state_q)
            StIdle: begin
                if (pstart && !tmr.abort) begin
                    ceil_d     = tmr.ceil;
                    periodic_d = tmr.periodic;
                    count_d    = '0;
                    pre_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (tmr.abort) begin
                    count_d = '0;
                    pre_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (pstart && RETRIG) begin
                    // Restart wins over a same-cycle expiry; no done pulse.
                    ceil_d     = tmr.ceil;
                    periodic_d = tmr.periodic;
                    count_d    = '0;
                    pre_d      = '0;
                end else begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (expire) begin
                        done_d  = 1'b1;
                        count_d = '0;
                        if (!periodic_q) begin
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end
                    end else if (tick) begin
                        count_d = count_q + W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                count_d = '0;
                pre_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            pre_q      <= '0;
            ceil_q     <= '0;
            periodic_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            ceil_q     <= ceil_d;
            periodic_q <= periodic_d;
        end
    end

    assign tmr.busy  = busy_q;
    assign tmr.done  = done_q;
    assign tmr.count = count_q;
endmodule

// File: tb/tb_oled_interval_timer.sv
// Scoreboard bench: expected done cycles are queued when a start is driven and
// matched against observed done pulses; busy/count spot-checked per scenario.
module tb_oled_interval_timer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   k;

    int exp_a[$];
    int exp_b[$];
    int exp_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oled_interval_timer_if #(.W(4)) ia ();
    oled_interval_timer_if #(.W(4)) ib ();
    oled_interval_timer_if #(.W(4)) ic ();

    oled_interval_timer #(.W(4), .DIV(1), .RETRIG(1'b0)) u_a (.clk(clk), .rst(rst), .tmr(ia));
    oled_interval_timer #(.W(4), .DIV(2), .RETRIG(1'b0)) u_b (.clk(clk), .rst(rst), .tmr(ib));
    oled_interval_timer #(.W(4), .DIV(1), .RETRIG(1'b1)) u_c (.clk(clk), .rst(rst), .tmr(ic));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Done monitors: every pulse must match the head of its queue.
    always @(negedge clk) begin
        if (ia.done === 1'b1) begin
            if (exp_a.size() == 0) check("a_done_unexpected", ia.done, 0);
            else check("a_done_cycle", cyc, exp_a.pop_front());
        end
        if (ib.done === 1'b1) begin
            if (exp_b.size() == 0) check("b_done_unexpected", ib.done, 0);
            else check("b_done_cycle", cyc, exp_b.pop_front());
        end
        if (ic.done === 1'b1) begin
            if (exp_c.size() == 0) check("c_done_unexpected", ic.done, 0);
            else check("c_done_cycle", cyc, exp_c.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        ia.start = 1'b0; ia.abort = 1'b0; ia.periodic = 1'b0; ia.ceil = '0;
        ib.start = 1'b0; ib.abort = 1'b0; ib.periodic = 1'b0; ib.ceil = '0;
        ic.start = 1'b0; ic.abort = 1'b0; ic.periodic = 1'b0; ic.ceil = '0;
        repeat (3) @(negedge clk);
        check("rst_busy_a", ia.busy, 0);
        check("rst_done_a", ia.done, 0);
        check("rst_count_a", ia.count, 0);
        check("rst_busy_b", ib.busy, 0);
        check("rst_count_c", ic.count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // One-shot, L=5, start held 20 cycles
        ia.ceil = 4'd5; ia.periodic = 1'b0;
        k = cyc; ia.start = 1'b1; exp_a.push_back(k + 6);
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            check("t1_busy", ia.busy, (j <= 5) ? 1 : 0);
            check("t1_count", ia.count, (j <= 5) ? j - 1 : 0);
        end
        repeat (13) @(negedge clk);
        ia.start = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_q_empty", exp_a.size(), 0);

        // Periodic, DIV=2, L=3: period 6; ceil/mode changes mid-run ignored
        ib.ceil = 4'd3; ib.periodic = 1'b1;
        k = cyc; ib.start = 1'b1;
        exp_b.push_back(k + 7); exp_b.push_back(k + 13); exp_b.push_back(k + 19);
        @(negedge clk); ib.start = 1'b0;
        repeat (3) @(negedge clk);
        ib.ceil = 4'd9; ib.periodic = 1'b0;
        repeat (18) @(negedge clk);
        check("t2_busy", ib.busy, 1);
        check("t2_count", ib.count, 1);
        ib.abort = 1'b1;
        @(negedge clk); ib.abort = 1'b0;
        check("t2_abort_busy", ib.busy, 0);
        check("t2_abort_count", ib.count, 0);
        repeat (8) @(negedge clk);
        check("t2_q_empty", exp_b.size(), 0);

        // ceil=0 means 16 ticks
        ia.ceil = 4'd0;
        k = cyc; ia.start = 1'b1; exp_a.push_back(k + 17);
        @(negedge clk); ia.start = 1'b0;
        repeat (15) @(negedge clk);
        check("t3_busy_last", ia.busy, 1);
        check("t3_count_last", ia.count, 15);
        @(negedge clk);
        check("t3_busy_end", ia.busy, 0);
        repeat (3) @(negedge clk);
        check("t3_q_empty", exp_a.size(), 0);

        // Abort mid-run
        ia.ceil = 4'd5;
        k = cyc; ia.start = 1'b1;
        @(negedge clk); ia.start = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_busy_pre_abort", ia.busy, 1);
        ia.abort = 1'b1;
        @(negedge clk); ia.abort = 1'b0;
        check("t4_busy_abort", ia.busy, 0);
        check("t4_count_abort", ia.count, 0);
        repeat (8) @(negedge clk);

        // Abort in the expiry cycle suppresses done
        k = cyc; ia.start = 1'b1;
        @(negedge clk); ia.start = 1'b0;
        repeat (4) @(negedge clk);
        check("t4b_count_last", ia.count, 4);
        ia.abort = 1'b1;
        @(negedge clk); ia.abort = 1'b0;
        check("t4b_busy", ia.busy, 0);
        check("t4b_done", ia.done, 0);
        repeat (8) @(negedge clk);

        // Second edge at +2: retrigger on u_c, ignored on u_a
        ia.ceil = 4'd4; ic.ceil = 4'd4;
        k = cyc; ia.start = 1'b1; ic.start = 1'b1;
        exp_a.push_back(k + 5); exp_c.push_back(k + 7);
        @(negedge clk); ia.start = 1'b0; ic.start = 1'b0;
        @(negedge clk); ia.start = 1'b1; ic.start = 1'b1;
        @(negedge clk); ia.start = 1'b0; ic.start = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_q_empty_a", exp_a.size(), 0);
        check("t5_q_empty_c", exp_c.size(), 0);

        // Reset mid-run with start held: edge re-seen right after release
        ia.ceil = 4'd5;
        k = cyc; ia.start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", ia.busy, 0);
        check("t6_rst_count", ia.count, 0);
        check("t6_rst_done", ia.done, 0);
        rst = 1'b0; exp_a.push_back(k + 10);
        @(negedge clk);
        check("t6_restart_busy", ia.busy, 1);
        repeat (11) @(negedge clk);
        check("t6_q_empty", exp_a.size(), 0);
        check("t6_no_retrigger", ia.busy, 0);
        ia.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
